// File: rtl/uart_cmd_rcv_if.sv
// Command-side bundle of the UART command receiver: assembled command,
// ready/acknowledge handshake and framing-error strobe.
interface uart_cmd_rcv_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;
  logic        clr_cmd_rdy;

  modport master (output cmd, output cmd_rdy, output frm_err, input clr_cmd_rdy);
  modport slave  (input cmd, input cmd_rdy, input frm_err, output clr_cmd_rdy);
endinterface

// File: rtl/uart_cmd_rcv.sv
// 8N1 UART byte receiver plus two-byte command assembler (high byte first)
// with inter-byte timeout and a level cmd_rdy cleared by the consumer.
module uart_cmd_rcv #(
  parameter int unsigned BAUD_DIV = 434,
  parameter int unsigned TIMEOUT  = 2_500_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RX,
  uart_cmd_rcv_if.master  bus
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RECV}       rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  rx_state_t  rx_state, rx_nxt;
  asm_state_t asm_state, asm_nxt;

  logic          rx_ff1, rx_ff2, rx_prev;
  logic          rx_fall;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          sample, last;
  logic          frame_end;
  logic          byte_done, frm_err;
  logic [7:0]    rx_byte;

  logic [7:0]    hold_byte;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          load_hi, load_cmd;
  logic [15:0]   cmd_r;
  logic          cmd_rdy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  assign rx_fall = rx_prev & ~rx_ff2;

  always_comb begin
    rx_nxt = rx_state;
    sample = 1'b0;
    last   = 1'b0;
    case (rx_state)
      IDLE: if (rx_fall) rx_nxt = RECV;
      RECV: begin
        if (baud_cnt == '0) begin
          sample = 1'b1;
          if (bit_cnt == 4'd0 && rx_ff2) begin
            rx_nxt = IDLE;
          end else if (bit_cnt == 4'd9) begin
            last   = 1'b1;
            rx_nxt = IDLE;
          end
        end
      end
      default: rx_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_end <= 1'b0;
    end else begin
      rx_state  <= rx_nxt;
      frame_end <= last;
      if (rx_state == IDLE) begin
        bit_cnt <= '0;
        if (rx_fall) baud_cnt <= BW'(BAUD_DIV / 2);
      end else if (sample) begin
        baud_cnt <= BW'(BAUD_DIV);
        bit_cnt  <= bit_cnt + 4'd1;
        shreg    <= {rx_ff2, shreg[9:1]};
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  // Frame status decoded one clock after the stop sample, once the stop bit
  // has shifted into shreg[9]; a high start bit never reaches here (aborted).
  assign byte_done = frame_end & ~shreg[0] & shreg[9];
  assign frm_err   = frame_end & ~shreg[9];
  assign rx_byte   = shreg[8:1];
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));

  always_comb begin
    asm_nxt  = asm_state;
    load_hi  = 1'b0;
    load_cmd = 1'b0;
    if (frm_err) begin
      asm_nxt = WAIT_HI;
    end else begin
      case (asm_state)
        WAIT_HI: if (byte_done) begin
          load_hi = 1'b1;
          asm_nxt = WAIT_LO;
        end
        WAIT_LO: if (byte_done) begin
          load_cmd = 1'b1;
          asm_nxt  = WAIT_HI;
        end else if (tmo_hit) begin
          asm_nxt = WAIT_HI;
        end
        default: asm_nxt = WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HI;
      hold_byte <= '0;
      tmo_cnt   <= '0;
      cmd_r     <= '0;
      cmd_rdy_r <= 1'b0;
    end else begin
      asm_state <= asm_nxt;
      if (load_hi) begin
        hold_byte <= rx_byte;
        tmo_cnt   <= '0;
      end else if (asm_state == WAIT_LO && rx_state == IDLE && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      // Set has priority over both clear sources.
      if (load_cmd) begin
        cmd_r     <= {hold_byte, rx_byte};
        cmd_rdy_r <= 1'b1;
      end else if (bus.clr_cmd_rdy || load_hi) begin
        cmd_rdy_r <= 1'b0;
      end
    end
  end

  assign bus.cmd     = cmd_r;
  assign bus.cmd_rdy = cmd_rdy_r;
  assign bus.frm_err = frm_err;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Self-checking bench for uart_cmd_rcv: serial stimulus with a scoreboard of
// expected commands, popped whenever cmd_rdy rises.
module tb_uart_cmd_rcv;

  localparam int unsigned BAUD = 53;
  localparam int unsigned TMO  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_cmd_rcv_if bus ();

  uart_cmd_rcv #(.BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  int          rdy_rises  = 0;
  int          frm_pulses = 0;
  int          frm_run    = 0;
  logic        rdy_q = 1'b0;
  logic        frm_q = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cmd_rdy && !rdy_q) begin
      rdy_rises++;
      if (exp_q.size() == 0) check_val("rdy_without_cmd", exp_q.size(), 1);
      else                   check_val("cmd", bus.cmd, exp_q.pop_front());
    end
    if (bus.frm_err) begin
      if (!frm_q) frm_pulses++;
      frm_run++;
    end else if (frm_q) begin
      check_val("frm_err_width", frm_run, 1);
      frm_run = 0;
    end
    rdy_q = bus.cmd_rdy;
    frm_q = bus.frm_err;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back({hi, lo});
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #(600_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rises_before;
    bus.clr_cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_cmd", bus.cmd, 0);
    check_val("reset_rdy", bus.cmd_rdy, 0);
    check_val("reset_frm", bus.frm_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command
    send_cmd(8'h20, 8'h00);
    check_val("rdy_after_2000", bus.cmd_rdy, 1);
    check_val("no_frm_2000", frm_pulses, 0);

    // Consumer acknowledge between commands
    pulse_clr();
    check_val("rdy_clr_2000", bus.cmd_rdy, 0);
    check_val("cmd_hold_2000", bus.cmd, 16'h2000);
    send_cmd(8'h60, 8'h23);
    check_val("rdy_after_6023", bus.cmd_rdy, 1);
    pulse_clr();
    check_val("rdy_clr_6023", bus.cmd_rdy, 0);
    check_val("cmd_hold_6023", bus.cmd, 16'h6023);

    // A new high byte clears an unconsumed cmd_rdy but keeps cmd
    send_cmd(8'h11, 8'h22);
    exp_q.push_back(16'h3344);
    send_byte(8'h33);
    check_val("rdy_clr_by_hi", bus.cmd_rdy, 0);
    check_val("cmd_kept_by_hi", bus.cmd, 16'h1122);
    send_byte(8'h44);
    check_val("rdy_after_3344", bus.cmd_rdy, 1);

    // Inter-byte timeout discards the held byte
    pulse_clr();
    send_byte(8'h40);
    repeat (TMO + 10) @(negedge clk);
    check_val("rdy_after_tmo", bus.cmd_rdy, 0);
    check_val("cmd_after_tmo", bus.cmd, 16'h3344);
    send_cmd(8'h50, 8'h07);
    check_val("rdy_after_5007", bus.cmd_rdy, 1);

    // Framing errors, in WAIT_HI and with a held byte
    pulse_clr();
    send_byte(8'h40, 1'b0);
    check_val("frm_count_1", frm_pulses, 1);
    send_cmd(8'h4F, 8'h02);
    pulse_clr();
    send_byte(8'h55);
    send_byte(8'h66, 1'b0);
    check_val("frm_count_2", frm_pulses, 2);
    check_val("rdy_after_frm", bus.cmd_rdy, 0);
    send_cmd(8'h4E, 8'h03);

    // Short low glitch must not start a byte
    pulse_clr();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    check_val("glitch_no_frm", frm_pulses, 2);
    send_cmd(8'h12, 8'h34);

    // Reset mid-byte while a high byte is held
    send_byte(8'h99);
    check_val("rdy_clr_by_99", bus.cmd_rdy, 0);
    check_val("cmd_before_rst", bus.cmd, 16'h1234);
    fork
      send_byte(8'hF0);
      begin
        repeat (5 * BAUD + BAUD / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_cmd", bus.cmd, 0);
        check_val("midrst_rdy", bus.cmd_rdy, 0);
        check_val("midrst_frm", bus.frm_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    send_cmd(8'h20, 8'h00);
    check_val("rdy_after_rst_2000", bus.cmd_rdy, 1);

    // Set wins over a simultaneous clear, then clears on the next edge
    pulse_clr();
    send_byte(8'h0A);
    rises_before = rdy_rises;
    exp_q.push_back(16'h0A0B);
    bus.clr_cmd_rdy = 1'b1;
    send_byte(8'h0B);
    bus.clr_cmd_rdy = 1'b0;
    check_val("set_wins_rise", rdy_rises, rises_before + 1);
    check_val("clr_after_set", bus.cmd_rdy, 0);
    check_val("cmd_0a0b", bus.cmd, 16'h0A0B);

    repeat (5) @(negedge clk);
    check_val("scoreboard_empty", exp_q.size(), 0);
    check_val("frm_total", frm_pulses, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
